regfile_multiport: RTL and testbench

Parametrised successor to the 8x8 register file. Configurable width and depth, same-cycle write-to-read bypass, and a secondary overflow write port targeting a configurable register. Adds a snapshot dump engine with a valid/ready stream in place of the flat per-register outputs. Sits between decode (read addresses), writeback (primary and overflow writes) and the debug/trace path (dump stream).

---
 rtl/regfile_multiport.sv | 121 ++++++++++++
 tb/tb_regfile_multiport.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Parametrised multiport register file with write bypass,
// an overflow write port and a snapshot dump stream.
module regfile_multiport #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int OVF_REG  = NUM_REGS - 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  input  logic [ADDR_W-1:0] rd_addrD_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [DATA_W-1:0] dataD_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              ovf_en_i,
  input  logic [DATA_W-1:0] ovf_data_i,
  input  logic              dump_start_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_busy_o,
  output logic              dump_done_o
);

  localparam logic [ADDR_W-1:0] OVF_A  = ADDR_W'(OVF_REG);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {IDLE, SEND} state_e;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] shadow_q;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              done_q, done_d;
  logic              snap_ld;

  // Next register contents; overflow write overrides the primary one
  always_comb begin
    regs_d = regs_q;
    if (wr_en_i) begin
      regs_d[wr_addr_i] = wr_data_i;
    end
    if (wr_en_i && ovf_en_i) begin
      regs_d[OVF_A] = ovf_data_i;
    end
  end

  // Reads see the post-edge value, except while in reset
  always_comb begin
    if (rst) begin
      data1_o = regs_q[rd_addr1_i];
      data2_o = regs_q[rd_addr2_i];
      dataD_o = regs_q[rd_addrD_i];
    end else begin
      data1_o = regs_d[rd_addr1_i];
      data2_o = regs_d[rd_addr2_i];
      dataD_o = regs_d[rd_addrD_i];
    end
  end

  // Dump engine next-state: snapshot on start, step on each accepted beat
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    snap_ld = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dump_start_i) begin
          state_d = SEND;
          idx_d   = '0;
          snap_ld = 1'b1;
        end
      end
      SEND: begin
        if (dump_ready_i) begin
          if (idx_q == LAST_A) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q   <= '0;
      shadow_q <= '0;
      state_q  <= IDLE;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      if (snap_ld) begin
        shadow_q <= regs_d;
      end
    end
  end

  assign dump_valid_o = (state_q == SEND);
  assign dump_busy_o  = (state_q == SEND);
  assign dump_idx_o   = idx_q;
  assign dump_done_o  = done_q;
  assign dump_data_o  = (state_q == SEND) ? shadow_q[idx_q] : '0;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench: default and 16x16/OVF_REG=0 instances in lockstep,
// each checked every cycle against an array/snapshot model.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, ovf_en, dump_start, dump_ready;
  logic [3:0]  wr_addr, ra1, ra2, raD;
  logic [15:0] wr_data, ovf_data;

  logic [7:0]  a_d1, a_d2, a_dD, a_dat;
  logic [2:0]  a_idx;
  logic        a_val, a_busy, a_done;
  logic [15:0] b_d1, b_d2, b_dD, b_dat;
  logic [3:0]  b_idx;
  logic        b_val, b_busy, b_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_multiport u_a (
    .clk(clk), .rst(rst),
    .rd_addr1_i(ra1[2:0]), .rd_addr2_i(ra2[2:0]),
    .rd_addrD_i(raD[2:0]),
    .data1_o(a_d1), .data2_o(a_d2), .dataD_o(a_dD),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr[2:0]),
    .wr_data_i(wr_data[7:0]),
    .ovf_en_i(ovf_en), .ovf_data_i(ovf_data[7:0]),
    .dump_start_i(dump_start), .dump_valid_o(a_val),
    .dump_ready_i(dump_ready), .dump_idx_o(a_idx),
    .dump_data_o(a_dat), .dump_busy_o(a_busy),
    .dump_done_o(a_done)
  );

  regfile_multiport #(
    .DATA_W(16), .NUM_REGS(16), .OVF_REG(0)
  ) u_b (
    .clk(clk), .rst(rst),
    .rd_addr1_i(ra1), .rd_addr2_i(ra2),
    .rd_addrD_i(raD),
    .data1_o(b_d1), .data2_o(b_d2), .dataD_o(b_dD),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .ovf_en_i(ovf_en), .ovf_data_i(ovf_data),
    .dump_start_i(dump_start), .dump_valid_o(b_val),
    .dump_ready_i(dump_ready), .dump_idx_o(b_idx),
    .dump_data_o(b_dat), .dump_busy_o(b_busy),
    .dump_done_o(b_done)
  );

  // reference model state, per instance k
  int          nr[2]   = '{8, 16};
  int          ovr[2]  = '{7, 0};
  logic [15:0] mask[2] = '{16'h00FF, 16'hFFFF};
  logic [15:0] mreg[2][16];
  logic [15:0] msnap[2][16];
  bit          mact[2];
  int          mpos[2];
  bit          mdone[2];
  bit          prst[2];

  function automatic logic [15:0] exp_rd(int k, logic [3:0] a0);
    int a;
    int w;
    a = int'(a0) % nr[k];
    w = int'(wr_addr) % nr[k];
    if (!rst && wr_en && ovf_en && a == ovr[k])
      return ovf_data & mask[k];
    if (!rst && wr_en && a == w)
      return wr_data & mask[k];
    return mreg[k][a];
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [15:0] rd[2][3];
    logic [15:0] dat[2], idx[2];
    logic        val[2], bsy[2], dn[2];
    logic [3:0]  ad[3];
    rd[0][0] = {8'h0, a_d1}; rd[0][1] = {8'h0, a_d2};
    rd[0][2] = {8'h0, a_dD};
    rd[1][0] = b_d1; rd[1][1] = b_d2; rd[1][2] = b_dD;
    dat[0] = {8'h0, a_dat}; dat[1] = b_dat;
    idx[0] = {13'h0, a_idx}; idx[1] = {12'h0, b_idx};
    val[0] = a_val; val[1] = b_val;
    bsy[0] = a_busy; bsy[1] = b_busy;
    dn[0] = a_done; dn[1] = b_done;
    ad[0] = ra1; ad[1] = ra2; ad[2] = raD;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 3; p++)
        chk($sformatf("u%0d_rd%0d", k, p), rd[k][p],
            exp_rd(k, ad[p]));
      chk($sformatf("u%0d_valid", k), 16'(val[k]), 16'(mact[k]));
      chk($sformatf("u%0d_busy", k), 16'(bsy[k]), 16'(mact[k]));
      chk($sformatf("u%0d_done", k), 16'(dn[k]), 16'(mdone[k]));
      if (mact[k]) begin
        chk($sformatf("u%0d_idx", k), idx[k], 16'(mpos[k]));
        chk($sformatf("u%0d_data", k), dat[k],
            msnap[k][mpos[k]]);
      end
      if (prst[k]) begin
        chk($sformatf("u%0d_rst_idx", k), idx[k], 16'h0);
        chk($sformatf("u%0d_rst_data", k), dat[k], 16'h0);
      end
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) mreg[k][i] = '0;
        mact[k] = 0; mpos[k] = 0; mdone[k] = 0; prst[k] = 1;
      end else begin
        prst[k] = 0;
        mdone[k] = 0;
        if (wr_en)
          mreg[k][int'(wr_addr) % nr[k]] = wr_data & mask[k];
        if (wr_en && ovf_en)
          mreg[k][ovr[k]] = ovf_data & mask[k];
        if (mact[k]) begin
          if (dump_ready) begin
            if (mpos[k] == nr[k] - 1) begin
              mact[k] = 0; mdone[k] = 1;
            end else begin
              mpos[k]++;
            end
          end
        end else if (dump_start) begin
          for (int i = 0; i < 16; i++) msnap[k][i] = mreg[k][i];
          mact[k] = 1; mpos[k] = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        mreg[k][i] = '0; msnap[k][i] = '0;
      end
      mact[k] = 0; mpos[k] = 0; mdone[k] = 0; prst[k] = 0;
    end
    rst = 1; wr_en = 0; ovf_en = 0; dump_start = 0;
    dump_ready = 0; wr_addr = 0; ra1 = 0; ra2 = 0; raD = 0;
    wr_data = 0; ovf_data = 0;
    @(negedge clk);
    cycle(); cycle();
    rst = 0;

    // all addresses read zero after reset
    for (int a = 0; a < 16; a++) begin
      ra1 = 4'(a); ra2 = 4'(15 - a); raD = 4'(a);
      cycle();
    end

    // bypass then storage
    wr_en = 1; wr_addr = 3; wr_data = 16'h00A5;
    ra1 = 3; ra2 = 3; raD = 3;
    cycle();
    wr_en = 0;
    cycle();

    // overflow write with conflicting primary address
    wr_en = 1; wr_addr = 7; wr_data = 16'h0011;
    ovf_en = 1; ovf_data = 16'h0022;
    ra1 = 7; ra2 = 0; raD = 3;
    cycle();
    wr_en = 0; ovf_data = 16'h0033;
    cycle();
    ovf_en = 0;
    cycle();

    // load reg[i] = i + 0x10 and dump with ready high
    for (int i = 15; i >= 0; i--) begin
      wr_en = 1; wr_addr = 4'(i); wr_data = 16'(i + 16'h10);
      cycle();
    end
    wr_en = 0;
    dump_start = 1; dump_ready = 1;
    cycle();
    dump_start = 0;
    repeat (20) cycle();

    // stalling dump with a live write to reg2
    dump_start = 1;
    cycle();
    dump_start = 0;
    for (int c = 0; c < 40; c++) begin
      dump_ready = (c % 2 == 0);
      wr_en = (c == 3); wr_addr = 2; wr_data = 16'h00FF;
      ra1 = 2;
      cycle();
    end
    wr_en = 0;

    // reset in the middle of a dump, then a fresh dump
    dump_start = 1; dump_ready = 1;
    cycle();
    dump_start = 0;
    repeat (4) cycle();
    rst = 1;
    cycle();
    rst = 0;
    cycle();
    dump_start = 1;
    cycle();
    dump_start = 0;
    repeat (20) cycle();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      wr_en = $urandom_range(0, 1) == 1;
      ovf_en = $urandom_range(0, 2) == 0;
      wr_addr = 4'($urandom);
      wr_data = 16'($urandom);
      ovf_data = 16'($urandom);
      ra1 = 4'($urandom); ra2 = 4'($urandom);
      raD = $urandom_range(0, 3) == 0 ? wr_addr : 4'($urandom);
      dump_start = $urandom_range(0, 5) == 0;
      dump_ready = $urandom_range(0, 3) != 0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
